// File: rtl/mem_sram_slave.sv
// mem_sram_slave: valid/ready memory responder backed by a word-addressed SRAM model.
// Accepts one request at a time, performs the access after WAIT_CYCLES wait states,
// and holds a registered response until the initiator takes it.
module mem_sram_slave #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_sel_i,
    input  logic        req_we_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_sel;
    logic        r_we;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_hs, w_enter_resp;
    logic [31:0] w_a_addr, w_a_wdata;
    logic [3:0]  w_a_sel;
    logic        w_a_we;
    logic [29:0] w_word;
    logic        w_err;
    logic [AW-1:0] w_idx;

    assign req_ready_o  = (r_state == S_IDLE);
    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_rdata_o  = r_rdata;
    assign rsp_err_o    = r_err;
    assign w_hs         = req_valid_i & req_ready_o;
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    // With zero wait states the access happens on the accept edge itself, so the
    // live request inputs are used in IDLE; otherwise the latched copy is used.
    assign w_a_addr  = (r_state == S_IDLE) ? req_addr_i  : r_addr;
    assign w_a_wdata = (r_state == S_IDLE) ? req_wdata_i : r_wdata;
    assign w_a_sel   = (r_state == S_IDLE) ? req_sel_i   : r_sel;
    assign w_a_we    = (r_state == S_IDLE) ? req_we_i    : r_we;

    // Full 30-bit compare so out-of-range addresses never alias into the array.
    assign w_word = w_a_addr[31:2];
    assign w_err  = ({2'b00, w_word} >= 32'(DEPTH));
    assign w_idx  = w_word[AW-1:0];

    // Next-state and wait counter decode
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_RESP;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            S_RESP: begin
                if (rsp_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request at the handshake; inputs are free to change afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_sel   <= 4'd0;
            r_we    <= 1'b0;
        end else if (w_hs) begin
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_sel   <= req_sel_i;
            r_we    <= req_we_i;
        end
    end

    // Response registers, updated only when entering RESP and held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_a_we) ? 32'd0 : r_mem[w_idx];
        end
    end

    // Byte-lane write into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_a_we && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_a_sel[k]) r_mem[w_idx][8*k +: 8] <= w_a_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_sram_slave.sv
// Bench for mem_sram_slave: three instances (WAIT_CYCLES 1, 0, 3) driven by a
// directed sequence; expected responses come from a reference word model and
// are queued at request time, then popped when the response appears.
module tb_mem_sram_slave;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [2:0][31:0]  req_addr, req_wdata, rsp_rdata;
    logic [2:0][3:0]   req_sel;

    mem_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .req_wdata_i(req_wdata[0]), .req_sel_i(req_sel[0]), .req_we_i(req_we[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));

    mem_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .req_wdata_i(req_wdata[1]), .req_sel_i(req_sel[1]), .req_we_i(req_we[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));

    mem_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_addr_i(req_addr[2]),
        .req_wdata_i(req_wdata[2]), .req_sel_i(req_sel[2]), .req_we_i(req_we[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
        .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [longint];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int wc(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One transaction on instance d. Called and returns at a falling edge.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel, input int bp,
                       output logic [31:0] rd, output longint hs_t);
        exp_t   e;
        longint key;
        logic [31:0] w;
        int     n;
        key = (longint'(d) << 32) + longint'(addr[31:2]);
        if (addr[31:2] >= 30'(DEPTH)) begin
            e.rdata = 32'd0; e.err = 1'b1;
        end else if (we) begin
            w = mdl.exists(key) ? mdl[key] : 32'd0;
            for (int k = 0; k < 4; k++) if (sel[k]) w[8*k +: 8] = wdata[8*k +: 8];
            mdl[key] = w;
            e.rdata = 32'd0; e.err = 1'b0;
        end else begin
            e.rdata = mdl.exists(key) ? mdl[key] : 32'd0; e.err = 1'b0;
        end
        sb.push_back(e);

        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_sel[d] = sel;
        n = 0;
        while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("accept_timeout", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        hs_t = longint'($time);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d] = $urandom; req_wdata[d] = $urandom; req_sel[d] = 4'($urandom);
        req_we[d] = 1'($urandom);
        n = 1;
        while (!rsp_valid[d] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("rsp_timeout", 32'(rsp_valid[d]), 32'd1);
        chk($sformatf("latency_d%0d", d), 32'(n), 32'(wc(d) + 1));
        e = sb.pop_front();
        chk($sformatf("rdata_d%0d_%h", d, addr), rsp_rdata[d], e.rdata);
        chk($sformatf("err_d%0d_%h", d, addr), 32'(rsp_err[d]), 32'(e.err));
        rd = rsp_rdata[d];
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid[d]), 32'd1);
            chk("bp_rdata", rsp_rdata[d], rd);
            chk("bp_req_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("turnaround_ready", 32'(req_ready[d]), 32'd1);
        chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        longint t0, t1;
        req_valid = '0; req_we = '0; rsp_ready = '0;
        req_addr = '0; req_wdata = '0; req_sel = '0;

        // reset state on all instances
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'd0);
            chk("rst_err", 32'(rsp_err[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // basic write then read, WAIT_CYCLES=1
        txn(0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, rd, t0);
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, rd, t0);
        chk("basic_read", rd, 32'hDEADBEEF);

        // byte lanes
        txn(0, 1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 0, rd, t0);
        txn(0, 1'b1, 32'h0000_0020, 32'h00AB0000, 4'b0100, 0, rd, t0);
        txn(0, 1'b0, 32'h0000_0022, 32'h0, 4'h3, 0, rd, t0);
        chk("lane_merge", rd, 32'h11AB3344);
        txn(0, 1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, 0, rd, t0);
        txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, rd, t0);
        chk("sel_zero", rd, 32'h11AB3344);

        // out of range; word 0 must survive the errored write
        txn(0, 1'b1, 32'h0000_0000, 32'hA5A5_5A5A, 4'hF, 0, rd, t0);
        txn(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 0, rd, t0);
        txn(0, 1'b1, 32'h0000_3FFC, 32'h0BAD_F00D, 4'hF, 0, rd, t0);
        txn(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 0, rd, t0);
        txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, rd, t0);
        chk("no_alias_word0", rd, 32'hA5A5_5A5A);

        // back-pressure for 5 cycles on a read
        txn(0, 1'b0, 32'h0000_3FFC, 32'h0, 4'h0, 5, rd, t0);
        chk("bp_read", rd, 32'h0BAD_F00D);

        // accept spacing: WAIT_CYCLES=0 -> 2 cycles, WAIT_CYCLES=3 -> 5 cycles
        txn(1, 1'b1, 32'h0000_0100, 32'h0102_0304, 4'hF, 0, rd, t0);
        txn(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, rd, t1);
        chk("spacing_w0", 32'((t1 - t0) / 10), 32'd2);
        chk("w0_read", rd, 32'h0102_0304);
        txn(2, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0, rd, t0);
        txn(2, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, rd, t1);
        chk("spacing_w3", 32'((t1 - t0) / 10), 32'd5);

        // reset during WAIT discards the pending write
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h0000_0040;
        req_wdata[2] = 32'hCAFEF00D; req_sel[2] = 4'hF;
        chk("pre_rst_ready", 32'(req_ready[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("in_wait_ready", 32'(req_ready[2]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready[2]), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("midrst_rdata", rsp_rdata[2], 32'd0);
        chk("midrst_err", 32'(rsp_err[2]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(2, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, rd, t0);
        chk("rst_discard_write", rd, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
